// File: rtl/flash_reader_if.sv
// Host-side request/response bundle for flash_reader: one read request with its
// byte address, answered by an ack pulse carrying the data byte.
interface flash_reader_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [7:0]  data;
    logic        busy;

    modport master (output req, output addr, input ack, input data, input busy);
    modport slave  (input req, input addr, output ack, output data, output busy);
endinterface

// File: rtl/flash_reader.sv
// SPI flash byte reader: issues READ (0x03) + 24-bit address in SPI mode 0 and
// keeps CS low afterwards so that the next consecutive byte streams with no command.
module flash_reader #(
    parameter int unsigned SCK_DIV      = 2,
    parameter logic [23:0] BASE_ADDR    = 24'h100000,
    parameter int unsigned CS_HIGH_MIN  = 4,
    parameter int unsigned HOLD_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    flash_reader_if.slave host,
    output logic          flash_cs,
    output logic          flash_sclk,
    output logic          flash_mosi,
    input  logic          flash_miso
);
    localparam logic [7:0]  READ_CMD  = 8'h03;
    localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);
    localparam logic [15:0] CS_LAST   = 16'(CS_HIGH_MIN - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, CSWAIT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [31:0] shift_out_reg, shift_out_next;
    logic [6:0]  shift_in_reg, shift_in_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] last_addr_reg, last_addr_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        to_idle_reg, to_idle_next;
    logic        ack_reg, ack_next;
    logic [7:0]  data_reg, data_next;
    logic        cs_reg, cs_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;

    logic [15:0] start_addr;
    logic [31:0] start_word;
    logic        sequential;
    logic        half_end;
    logic [7:0]  sampled;
    logic [4:0]  field_last;

    // A command starts either straight from IDLE (live address) or after CSWAIT (captured one).
    assign start_addr = (state_reg == IDLE) ? host.addr : addr_reg;
    assign start_word = {READ_CMD, BASE_ADDR + {8'h00, start_addr}};
    // 17-bit compare so that 0xFFFF -> 0x0000 never counts as consecutive.
    assign sequential = ({1'b0, host.addr} == ({1'b0, last_addr_reg} + 17'd1));
    assign half_end   = (div_cnt_reg == DIV_LAST);
    assign sampled    = {shift_in_reg, flash_miso};
    assign field_last = (state_reg == ADDR) ? 5'd23 : 5'd7;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_out_reg <= '0;
            shift_in_reg  <= '0;
            addr_reg      <= '0;
            last_addr_reg <= '0;
            wait_cnt_reg  <= '0;
            to_idle_reg   <= 1'b0;
            ack_reg       <= 1'b0;
            data_reg      <= '0;
            cs_reg        <= 1'b1;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_out_reg <= shift_out_next;
            shift_in_reg  <= shift_in_next;
            addr_reg      <= addr_next;
            last_addr_reg <= last_addr_next;
            wait_cnt_reg  <= wait_cnt_next;
            to_idle_reg   <= to_idle_next;
            ack_reg       <= ack_next;
            data_reg      <= data_next;
            cs_reg        <= cs_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_out_next = shift_out_reg;
        shift_in_next  = shift_in_reg;
        addr_next      = addr_reg;
        last_addr_next = last_addr_reg;
        wait_cnt_next  = wait_cnt_reg;
        to_idle_next   = to_idle_reg;
        ack_next       = 1'b0;
        data_next      = data_reg;
        cs_next        = cs_reg;
        sclk_next      = sclk_reg;
        mosi_next      = mosi_reg;

        unique case (state_reg)
            IDLE: begin
                if (host.req) begin
                    addr_next      = host.addr;
                    state_next     = CMD;
                    cs_next        = 1'b0;
                    sclk_next      = 1'b0;
                    div_cnt_next   = '0;
                    bit_cnt_next   = '0;
                    mosi_next      = start_word[31];
                    shift_out_next = {start_word[30:0], 1'b0};
                end
            end

            CMD, ADDR, DATA: begin
                if (!half_end) begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end else begin
                    div_cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        // End of the high half: sample MISO, start the next low half.
                        sclk_next      = 1'b0;
                        shift_in_next  = sampled[6:0];
                        bit_cnt_next   = bit_cnt_reg + 5'd1;
                        mosi_next      = shift_out_reg[31];
                        shift_out_next = {shift_out_reg[30:0], 1'b0};
                        if (bit_cnt_reg == field_last) begin
                            bit_cnt_next = '0;
                            if (state_reg == CMD) begin
                                state_next = ADDR;
                            end else if (state_reg == ADDR) begin
                                state_next = DATA;
                            end else begin
                                state_next     = HOLD;
                                ack_next       = 1'b1;
                                data_next      = sampled;
                                mosi_next      = 1'b0;
                                wait_cnt_next  = '0;
                                last_addr_next = addr_reg;
                            end
                        end
                    end
                end
            end

            HOLD: begin
                // The ack cycle still sees the previous request held high; skip it.
                if (host.req && !ack_reg) begin
                    addr_next = host.addr;
                    if (sequential) begin
                        state_next   = DATA;
                        sclk_next    = 1'b0;
                        mosi_next    = 1'b0;
                        div_cnt_next = '0;
                        bit_cnt_next = '0;
                    end else begin
                        state_next    = CSWAIT;
                        cs_next       = 1'b1;
                        wait_cnt_next = '0;
                        to_idle_next  = 1'b0;
                    end
                end else if (wait_cnt_reg == HOLD_LAST) begin
                    state_next    = CSWAIT;
                    cs_next       = 1'b1;
                    wait_cnt_next = '0;
                    to_idle_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            CSWAIT: begin
                if (wait_cnt_reg == CS_LAST) begin
                    if (to_idle_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next     = CMD;
                        cs_next        = 1'b0;
                        sclk_next      = 1'b0;
                        div_cnt_next   = '0;
                        bit_cnt_next   = '0;
                        mosi_next      = start_word[31];
                        shift_out_next = {start_word[30:0], 1'b0};
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign host.ack   = ack_reg;
    assign host.data  = data_reg;
    assign host.busy  = (state_reg != IDLE) && (state_reg != HOLD);
    assign flash_cs   = cs_reg;
    assign flash_sclk = sclk_reg;
    assign flash_mosi = mosi_reg;
endmodule
